// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data load/store.
// Optional build macro ARB_ROUND_ROBIN_EN swaps starvation-limited data priority for round-robin.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] CNT_RELOAD = 4'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;

  logic open_w;
  logic rd_done;
  logic pick_dm;
  logic gnt_if;
  logic gnt_dm;
  logic rd_gnt;

  // Reset also gates the open window so no grant leaks out while rst_i is held.
  assign open_w  = !rst_i && ((state_q == S_IDLE) || (cnt_q == '0));
  assign rd_done = (state_q == S_WAIT) && (cnt_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q;

  always_comb begin
    pick_dm = dm_req_i && (!if_req_i || (last_q == OWN_IF));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWN_DM;
    end else if (gnt_if) begin
      last_q <= OWN_IF;
    end else if (gnt_dm) begin
      last_q <= OWN_DM;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;

  always_comb begin
    pick_dm = dm_req_i && (!if_req_i || (starve_q != STARVE_MAX));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (!if_req_i || gnt_if) begin
      starve_q <= '0;
    end else if (gnt_dm && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`endif

  assign gnt_dm = open_w && pick_dm;
  assign gnt_if = open_w && if_req_i && !pick_dm;
  assign rd_gnt = gnt_if || (gnt_dm && !dm_we_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (state_q == S_WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = S_IDLE;
      end
    end
    // A read grant only happens when open, so it can safely override the retire path.
    if (rd_gnt) begin
      state_d = S_WAIT;
      cnt_d   = CNT_RELOAD;
      owner_d = gnt_dm ? OWN_DM : OWN_IF;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    if_gnt_o    = gnt_if;
    dm_gnt_o    = gnt_dm;
    mem_req_o   = gnt_if || gnt_dm;
    mem_we_o    = gnt_dm && dm_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_dm) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (gnt_if) begin
      mem_addr_o  = if_addr_i;
    end
  end

  always_comb begin
    if_rvalid_o = rd_done && (owner_q == OWN_IF);
    dm_rvalid_o = rd_done && (owner_q == OWN_DM);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    busy_o      = (state_q == S_WAIT);
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table, directed sequences, read-data scoreboard.
module tb_unified_mem_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  // Main DUT (MEM_LATENCY=2, STARVE_LIMIT=4)
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Second DUT (MEM_LATENCY=1) for back-to-back fetch
  logic        d1_if_req, d1_if_gnt, d1_if_rvalid;
  logic [31:0] d1_if_addr, d1_if_rdata;
  logic        d1_dm_req, d1_dm_we, d1_dm_gnt, d1_dm_rvalid;
  logic [31:0] d1_dm_addr, d1_dm_wdata, d1_dm_rdata;
  logic        d1_mem_req, d1_mem_we, d1_busy;
  logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(d1_if_req), .if_addr_i(d1_if_addr), .if_gnt_o(d1_if_gnt),
    .if_rvalid_o(d1_if_rvalid), .if_rdata_o(d1_if_rdata),
    .dm_req_i(d1_dm_req), .dm_we_i(d1_dm_we), .dm_addr_i(d1_dm_addr), .dm_wdata_i(d1_dm_wdata),
    .dm_gnt_o(d1_dm_gnt), .dm_rvalid_o(d1_dm_rvalid), .dm_rdata_o(d1_dm_rdata),
    .mem_req_o(d1_mem_req), .mem_we_o(d1_mem_we), .mem_addr_o(d1_mem_addr),
    .mem_wdata_o(d1_mem_wdata), .mem_rdata_i(d1_mem_rdata), .busy_o(d1_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories: read data appears MEM_LATENCY cycles after the request.
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] pipe0, pipe1, d1_pipe0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] d1_mem_rd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    pipe0    <= (mem_req && !mem_we) ? mem_rd(mem_addr) : 32'hFFFF_FFFF;
    pipe1    <= pipe0;
    d1_pipe0 <= (d1_mem_req && !d1_mem_we) ? d1_mem_rd(d1_mem_addr) : 32'hFFFF_FFFF;
    if (mem_req && mem_we) mem_model[mem_addr] = mem_wdata;
  end

  assign mem_rdata    = pipe1;
  assign d1_mem_rdata = d1_pipe0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];

  function automatic void sb_push(input bit is_dm, input logic [31:0] data, input int lat);
    sb_t e;
    e.is_dm = is_dm;
    e.data  = data;
    e.due   = cyc + lat;
    sb.push_back(e);
  endfunction

  // Read-return monitor for the main DUT, plus reset-time output checks.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      chk("reset_outputs_zero", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                       mem_req, mem_we, mem_addr, mem_wdata, busy,
                                       d1_if_gnt, d1_if_rvalid, d1_dm_gnt, d1_dm_rvalid, d1_busy}), 64'd0);
    end else begin
      if (!if_rvalid) chk("if_rdata_zero_when_idle", 64'(if_rdata), 64'd0);
      if (!dm_rvalid) chk("dm_rdata_zero_when_idle", 64'(dm_rdata), 64'd0);
      if (if_rvalid || dm_rvalid) begin
        chk("single_rvalid", 64'(if_rvalid && dm_rvalid), 64'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got if=%0b dm=%0b expected none (cycle %0d)",
                   if_rvalid, dm_rvalid, cyc);
        end else begin
          e = sb.pop_front();
          chk("rvalid_port_is_dm", 64'(dm_rvalid), 64'(e.is_dm));
          chk("rvalid_data", 64'(dm_rvalid ? dm_rdata : if_rdata), 64'(e.data));
          chk("rvalid_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ifr, input logic [31:0] ia, input bit dmr, input bit we,
                       input logic [31:0] da, input logic [31:0] wd);
    if_req   = ifr;
    if_addr  = ia;
    dm_req   = dmr;
    dm_we    = we;
    dm_addr  = da;
    dm_wdata = wd;
  endtask

  // Checks this cycle's grant outputs against the bench's expectation; queues expected read data.
  task automatic expect_grant(input string nm, input bit eif, input bit edm,
                              input bit ovr = 1'b0, input logic [31:0] ovr_data = '0);
    #1;
    chk({nm, ":if_gnt"}, 64'(if_gnt), 64'(eif));
    chk({nm, ":dm_gnt"}, 64'(dm_gnt), 64'(edm));
    chk({nm, ":mem_req"}, 64'(mem_req), 64'(eif | edm));
    if (edm) begin
      chk({nm, ":mem_addr"}, 64'(mem_addr), 64'(dm_addr));
      chk({nm, ":mem_we"}, 64'(mem_we), 64'(dm_we));
      chk({nm, ":mem_wdata"}, 64'(mem_wdata), 64'(dm_wdata));
      if (!dm_we) sb_push(1'b1, ovr ? ovr_data : mem_rd(dm_addr), 2);
    end else if (eif) begin
      chk({nm, ":mem_addr"}, 64'(mem_addr), 64'(if_addr));
      chk({nm, ":mem_we"}, 64'(mem_we), 64'd0);
      sb_push(1'b0, ovr ? ovr_data : mem_rd(if_addr), 2);
    end else begin
      chk({nm, ":mem_we"}, 64'(mem_we), 64'd0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy=1 expected 0 within 20 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    string       nm;
    bit          ifr;
    bit          dmr;
    bit          we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    bit          exp_if;
    bit          exp_dm;
  } vec_t;

  vec_t tv[8];

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bit          exp_if, exp_dm;
    bit          rr_last_if;
    logic [31:0] ia, da;
    string       seq;

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    d1_if_req = 1'b0; d1_if_addr = '0;
    d1_dm_req = 1'b0; d1_dm_we = 1'b0; d1_dm_addr = '0; d1_dm_wdata = '0;
    mem_model[32'h100] = 32'hDEAD_BEEF;

    tv[0] = '{"if_read_0x100",   1, 0, 0, 32'h0000_0100, 32'h0,         32'h0,         1, 0};
    tv[1] = '{"dm_read",         0, 1, 0, 32'h0,         32'h0000_0200, 32'h0000_0BAD, 0, 1};
    tv[2] = '{"dm_write",        0, 1, 1, 32'h0,         32'h0000_0300, 32'h1111_2222, 0, 1};
    tv[3] = '{"both_read",       1, 1, 0, 32'h0000_0048, 32'h0000_0044, 32'h0,         0, 1};
    tv[4] = '{"both_dm_write",   1, 1, 1, 32'h0000_0058, 32'h0000_0050, 32'h0000_A5A5, 0, 1};
    tv[5] = '{"no_request",      0, 0, 0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0, 0};
    tv[6] = '{"if_read_top",     1, 0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1, 0};
    tv[7] = '{"dm_write_ones",   0, 1, 1, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1};

    step();
    step();
    rst = 1'b0;
    rr_last_if = 1'b0;
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);

    // Table-driven single-grant vectors, each starting from idle.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      step();
      drive(tv[i].ifr, tv[i].ia, tv[i].dmr, tv[i].we, tv[i].da, tv[i].wd);
      exp_if = tv[i].exp_if;
      exp_dm = tv[i].exp_dm;
`ifdef ARB_ROUND_ROBIN_EN
      if (tv[i].ifr && tv[i].dmr) begin
        exp_dm = rr_last_if;
        exp_if = !rr_last_if;
      end
      if (exp_if) rr_last_if = 1'b1;
      else if (exp_dm) rr_last_if = 1'b0;
`endif
      expect_grant(tv[i].nm, exp_if, exp_dm);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      wait_idle();
    end

    // Both ports reading continuously from reset: grants land every other cycle.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    seq = "IDIDID";
`else
    seq = "DDDDID";
`endif
    ia = 32'h0000_1000;
    da = 32'h0000_2000;
    for (int k = 0; k < 12; k++) begin
      step();
      drive(1'b1, ia, 1'b1, 1'b0, da, '0);
      if (k % 2 == 0) begin
        exp_dm = (seq[k / 2] == "D");
        expect_grant($sformatf("contend_%0d", k), !exp_dm, exp_dm);
        if (exp_dm) da = da + 32'd4;
        else ia = ia + 32'd4;
      end else begin
        expect_grant($sformatf("contend_%0d", k), 1'b0, 1'b0);
      end
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    wait_idle();

    // Write 0x5 to 0x40, then read it back on the next cycle.
    step();
    drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0005);
    expect_grant("raw_write", 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    expect_grant("raw_read", 1'b0, 1'b1, 1'b1, 32'h0000_0005);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    wait_idle();

    // Reset one cycle after a read grant: the read is abandoned.
    step();
    drive(1'b1, 32'h0000_0600, 1'b0, 1'b0, '0, '0);
    expect_grant("pre_reset_read", 1'b1, 1'b0);
    step();
    rst = 1'b1;
    sb.delete();
    drive(1'b1, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0704, '0);
    #1;
    chk("in_reset_busy", 64'(busy), 64'd0);
    chk("in_reset_if_gnt", 64'(if_gnt), 64'd0);
    step();
    step();
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    chk("after_reset_busy", 64'(busy), 64'd0);
    repeat (3) step();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0);
    expect_grant("post_reset_read", 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    wait_idle();

    // MEM_LATENCY=1 instance: three back-to-back fetches.
    step();
    d1_if_req = 1'b1; d1_if_addr = 32'h0;
    #1;
    chk("ml1_c0_gnt", 64'(d1_if_gnt), 64'd1);
    chk("ml1_c0_rvalid", 64'(d1_if_rvalid), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k < 3) d1_if_addr = 32'(4 * k);
      else d1_if_req = 1'b0;
      #1;
      chk($sformatf("ml1_c%0d_gnt", k), 64'(d1_if_gnt), 64'(k < 3));
      chk($sformatf("ml1_c%0d_rvalid", k), 64'(d1_if_rvalid), 64'd1);
      chk($sformatf("ml1_c%0d_rdata", k), 64'(d1_if_rdata), 64'(d1_mem_rd(32'(4 * (k - 1)))));
      chk($sformatf("ml1_c%0d_dm_rvalid", k), 64'(d1_dm_rvalid), 64'd0);
    end
    step();
    #1;
    chk("ml1_end_rvalid", 64'(d1_if_rvalid), 64'd0);
    chk("ml1_end_busy", 64'(d1_busy), 64'd0);

    repeat (4) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
